// File: rtl/systolic_operand_feeder_if.sv
// Host-write, control and skewed-vector signals between the operand feeder
// and its neighbours (host on the write side, MAC array on the stream side).
interface systolic_operand_feeder_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int BASE_LENGTH = 3,
  parameter int ARR_DIM     = 5
) ();
  localparam int AW = $clog2(ARR_DIM * BASE_LENGTH);

  logic                          wr_en;
  logic                          wr_sel;
  logic [AW-1:0]                 wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          go;
  logic                          hold;
  logic                          mac_done;
  logic [DATA_WIDTH*ARR_DIM-1:0] a_vec_out;
  logic [DATA_WIDTH*ARR_DIM-1:0] b_vec_out;
  logic                          mac_start;
  logic                          in_valid;
  logic                          w_valid;
  logic                          in_done;
  logic                          w_done;
  logic                          busy;
  logic                          feeder_done;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, go, hold, mac_done,
    input  a_vec_out, b_vec_out, mac_start, in_valid, w_valid,
           in_done, w_done, busy, feeder_done
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, go, hold, mac_done,
    output a_vec_out, b_vec_out, mac_start, in_valid, w_valid,
           in_done, w_done, busy, feeder_done
  );
endinterface

// File: rtl/systolic_operand_feeder.sv
// Buffers the A and B operand tiles and streams them into the systolic MAC
// array as diagonally skewed vectors, then waits for the array's done pulse.
module systolic_operand_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int BASE_LENGTH = 3,
  parameter int ARR_DIM     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_operand_feeder_if.slave bus
);
  localparam int DEPTH = ARR_DIM * BASE_LENGTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int STEPS = BASE_LENGTH + ARR_DIM - 1;
  localparam int TW    = $clog2(STEPS + 1);
  localparam int VW    = DATA_WIDTH * ARR_DIM;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [TW-1:0]         r_step;
  logic [TW-1:0]         w_step_nx;
  logic [TW-1:0]         w_t;
  logic [VW-1:0]         r_a_vec;
  logic [VW-1:0]         r_b_vec;
  logic [VW-1:0]         w_a_nx;
  logic [VW-1:0]         w_b_nx;
  logic [VW-1:0]         w_a_flat;
  logic [VW-1:0]         w_b_flat;
  logic                  r_start;
  logic                  w_start_nx;
  logic                  r_valid;
  logic                  w_valid_nx;
  logic                  r_last;
  logic                  w_last_nx;
  logic                  r_busy;
  logic                  r_fdone;
  logic                  w_fdone_nx;
  logic                  w_wr_ok;
  logic                  w_wr_a;
  logic                  w_wr_b;
  logic [DATA_WIDTH-1:0] r_a_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_b_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_a_rd  [DEPTH];
  logic [DATA_WIDTH-1:0] w_b_rd  [DEPTH];

  assign w_wr_ok = bus.wr_en && (r_state == ST_IDLE) && (32'(bus.wr_addr) < DEPTH);
  assign w_wr_a  = w_wr_ok && !bus.wr_sel;
  assign w_wr_b  = w_wr_ok && bus.wr_sel;

  // Tile buffers: host writes only, never cleared by reset
  always_ff @(posedge clk) begin
    if (w_wr_a) r_a_mem[bus.wr_addr] <= bus.wr_data;
    if (w_wr_b) r_b_mem[bus.wr_addr] <= bus.wr_data;
  end

  // Forward a write landing in the go cycle so step 0 already sees it
  for (genvar i = 0; i < DEPTH; i++) begin : g_rd
    assign w_a_rd[i] = (w_wr_a && bus.wr_addr == AW'(i)) ? bus.wr_data : r_a_mem[i];
    assign w_b_rd[i] = (w_wr_b && bus.wr_addr == AW'(i)) ? bus.wr_data : r_b_mem[i];
  end

  // Step about to be presented: 0 when launching from IDLE
  assign w_t = (r_state == ST_IDLE) ? '0 : r_step;

  // Lane g carries element index (t - g) along the reduction dimension
  for (genvar g = 0; g < ARR_DIM; g++) begin : g_lane
    logic [TW-1:0] w_d;
    logic          w_in;
    logic [AW-1:0] w_ai;
    logic [AW-1:0] w_bi;
    assign w_d  = w_t - TW'(g);
    assign w_in = (w_t >= TW'(g)) && (w_d < TW'(BASE_LENGTH));
    assign w_ai = AW'(g * BASE_LENGTH) + AW'(w_d);
    assign w_bi = AW'(w_d) * AW'(ARR_DIM) + AW'(g);
    assign w_a_flat[g*DATA_WIDTH +: DATA_WIDTH] = w_in ? w_a_rd[w_ai] : '0;
    assign w_b_flat[g*DATA_WIDTH +: DATA_WIDTH] = w_in ? w_b_rd[w_bi] : '0;
  end

  // Next state and next registered outputs
  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_a_nx     = '0;
    w_b_nx     = '0;
    w_start_nx = 1'b0;
    w_valid_nx = 1'b0;
    w_last_nx  = 1'b0;
    w_fdone_nx = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.go) begin
          w_state_nx = ST_STREAM;
          w_a_nx     = w_a_flat;
          w_b_nx     = w_b_flat;
          w_start_nx = 1'b1;
          w_valid_nx = 1'b1;
          w_last_nx  = (w_t == TW'(STEPS - 1));
          w_step_nx  = TW'(1);
        end else begin
          w_step_nx  = '0;
        end
      end
      ST_STREAM: begin
        w_start_nx = 1'b1;
        if (bus.hold) begin
          w_a_nx = r_a_vec;
          w_b_nx = r_b_vec;
        end else if (r_step == TW'(STEPS)) begin
          w_state_nx = ST_WAIT;
          w_step_nx  = '0;
        end else begin
          w_a_nx     = w_a_flat;
          w_b_nx     = w_b_flat;
          w_valid_nx = 1'b1;
          w_last_nx  = (w_t == TW'(STEPS - 1));
          w_step_nx  = r_step + TW'(1);
        end
      end
      ST_WAIT: begin
        if (bus.mac_done) begin
          w_state_nx = ST_IDLE;
          w_fdone_nx = 1'b1;
        end else begin
          w_start_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_step_nx  = '0;
      end
    endcase
  end

  // State, step counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_a_vec <= '0;
      r_b_vec <= '0;
      r_start <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_fdone <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
      r_a_vec <= w_a_nx;
      r_b_vec <= w_b_nx;
      r_start <= w_start_nx;
      r_valid <= w_valid_nx;
      r_last  <= w_last_nx;
      r_busy  <= (w_state_nx != ST_IDLE);
      r_fdone <= w_fdone_nx;
    end
  end

  assign bus.a_vec_out   = r_a_vec;
  assign bus.b_vec_out   = r_b_vec;
  assign bus.mac_start   = r_start;
  assign bus.in_valid    = r_valid;
  assign bus.w_valid     = r_valid;
  assign bus.in_done     = r_last;
  assign bus.w_done      = r_last;
  assign bus.busy        = r_busy;
  assign bus.feeder_done = r_fdone;
endmodule
